// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID pipeline constants: bus width, field positions and reset fetch address.
package if_id_queue_pkg;

    localparam int IF_ID_W  = 64;
    localparam int PC_MSB   = 63;
    localparam int PC_LSB   = 32;
    localparam int INST_MSB = 31;
    localparam int INST_LSB = 0;

    localparam logic [31:0] STARTADDR = 32'h0000_0034;

endpackage

// File: rtl/if_id_queue_kill_counter.sv
// 32-bit saturating accumulator of flushed instructions; one-cycle update, never stalls.
module ifq_kill_counter #(
    parameter int INC_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [INC_W-1:0] inc,
    output logic [31:0]      cnt
);

    logic [32:0] sum;

    assign sum = {1'b0, cnt} + {{(33-INC_W){1'b0}}, inc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction FIFO; a push is visible to decode one cycle later (no bypass).
// IF is held off only when full; exc/jbr redirects drop wrong-path entries (jbr keeps the delay slot).
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 IF_over,
    input  logic [IF_ID_W-1:0]   IF_ID_bus,
    output logic                 IF_allow_in,
    input  logic                 ID_allow_in,
    output logic                 ID_valid,
    output logic [IF_ID_W-1:0]   IFQ_ID_bus,
    input  logic                 jbr_flush,
    input  logic                 exc_flush,
    output logic [PTR_W:0]       IFQ_count,
    output logic [31:0]          IFQ_kill_cnt
);

    localparam int CNT_W  = PTR_W + 1;
    localparam int KILL_W = PTR_W + 2;

    logic [IF_ID_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               mem_we;
    logic [KILL_W-1:0]  kill_inc;

    assign IF_allow_in = (count != CNT_W'(DEPTH));
    assign ID_valid    = (count != '0);
    assign IFQ_ID_bus  = ID_valid ? mem[rd_ptr] : '0;
    assign IFQ_count   = count;

    assign push = IF_over & IF_allow_in;
    assign pop  = ID_valid & ID_allow_in;

    // A push survives a jbr redirect only when it becomes the delay slot itself.
    assign mem_we = push & ~exc_flush & (~jbr_flush | (count == '0));

    always_comb begin
        kill_inc = '0;
        if (exc_flush) begin
            kill_inc = KILL_W'(count) - KILL_W'(pop) + KILL_W'(push);
        end else if (jbr_flush && count != '0) begin
            kill_inc = KILL_W'(count) - KILL_W'(1) + KILL_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= IF_ID_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (exc_flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else if (jbr_flush) begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                wr_ptr <= rd_ptr + PTR_W'(1);
                count  <= '0;
            end else if (count != '0) begin
                wr_ptr <= rd_ptr + PTR_W'(1);
                count  <= CNT_W'(1);
            end else if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                count  <= CNT_W'(1);
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    ifq_kill_counter #(
        .INC_W (KILL_W)
    ) u_kill_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (kill_inc),
        .cnt    (IFQ_kill_cnt)
    );

endmodule
